// File: rtl/pulse_mode_sequencer_if.sv
// Datapath bus between the pulse-mode sequencer (master) and a combinational
// pulse-mode state-machine block (slave).
interface pulse_mode_sequencer_if;
    logic x1;
    logic x2;
    logic x3;
    logic y2;
    logic y1;
    logic ny2;
    logic ny1;
    logic z;

    modport master (
        output x1, x2, x3, y2, y1,
        input  ny2, ny1, z
    );

    modport slave (
        input  x1, x2, x3, y2, y1,
        output ny2, ny1, z
    );
endinterface

// File: rtl/pulse_mode_sequencer.sv
// Button-driven pulse-mode controller: conditions three buttons, grants one
// input pulse at a time and owns the {y2,y1} state register of the datapath.
module pulse_mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_3,
    input  logic                   btn_2,
    input  logic                   btn_0,
    pulse_mode_sequencer_if.master dp,
    output logic                   z_last,
    output logic [CNT_W-1:0]       z_count,
    output logic                   busy,
    output logic                   err
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        COMMIT = 2'd2,
        GAP    = 2'd3
    } state_t;

    // Bit k of every 3-bit vector below maps to pulse x(k+1).
    logic [2:0]      w_btn;
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_db;
    logic [2:0]      r_db_prev;
    logic [DB_W-1:0] r_db_cnt [3];

    logic [2:0]      w_edge;
    logic            w_multi;
    logic [2:0]      w_clr;
    logic [2:0]      w_kept;
    logic [2:0]      w_set;
    logic            w_dup;
    logic [2:0]      r_pending;
    logic            r_err;

    state_t          r_state;
    state_t          w_state_next;
    logic [2:0]      r_grant;
    logic [2:0]      w_grant_next;
    logic [2:0]      r_x;
    logic [2:0]      w_x_next;
    logic [1:0]      r_y;
    logic            r_z_last;
    logic [CNT_W-1:0] r_z_count;

    assign w_btn = {btn_0, btn_2, btn_3};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, like real hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_db      <= '0;
            r_db_prev <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it
            // is cleared explicitly along with the rest of the state.
            for (int k = 0; k < 3; k++) begin
                r_db_cnt[k] <= '0;
            end
        end else begin
            r_sync1   <= w_btn;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db;
            for (int k = 0; k < 3; k++) begin
                if (r_sync2[k] == r_db[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_LAST) begin
                    r_db[k]     <= ~r_db[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Simultaneous edges are illegal in pulse mode and are all discarded;
    // a fresh edge on a bit being cleared by COMMIT re-arms that bit.
    assign w_edge  = r_db & ~r_db_prev;
    assign w_multi = (w_edge[0] & w_edge[1]) | (w_edge[0] & w_edge[2]) |
                     (w_edge[1] & w_edge[2]);
    assign w_clr   = (r_state == COMMIT) ? r_grant : 3'b000;
    assign w_kept  = r_pending & ~w_clr;
    assign w_set   = w_multi ? 3'b000 : w_edge;
    assign w_dup   = |(w_set & w_kept);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= w_kept | w_set;
            r_err     <= r_err | w_multi | w_dup;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        unique case (r_state)
            IDLE: begin
                if (|r_pending) begin
                    w_state_next = APPLY;
                    if (r_pending[0])      w_grant_next = 3'b001;
                    else if (r_pending[1]) w_grant_next = 3'b010;
                    else                   w_grant_next = 3'b100;
                end
            end
            APPLY:   w_state_next = COMMIT;
            COMMIT:  w_state_next = GAP;
            GAP:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        w_x_next = ((w_state_next == APPLY) || (w_state_next == COMMIT)) ?
                   w_grant_next : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_z_last  <= 1'b0;
            r_z_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_x     <= w_x_next;
            if (r_state == COMMIT) begin
                r_y       <= {dp.ny2, dp.ny1};
                r_z_last  <= dp.z;
                r_z_count <= r_z_count + CNT_W'(dp.z);
            end
        end
    end

    assign dp.x1   = r_x[0];
    assign dp.x2   = r_x[1];
    assign dp.x3   = r_x[2];
    assign dp.y2   = r_y[1];
    assign dp.y1   = r_y[0];
    assign z_last  = r_z_last;
    assign z_count = r_z_count;
    assign busy    = (r_state != IDLE);
    assign err     = r_err;

endmodule

// File: tb/tb_pulse_mode_sequencer.sv
// Scoreboard bench for pulse_mode_sequencer with a mod-4 counter stub as the
// datapath; a monitor checks every completed x pulse against queued entries.
module tb_pulse_mode_sequencer;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       btn_3 = 1'b0;
    logic       btn_2 = 1'b0;
    logic       btn_0 = 1'b0;
    logic       z_last;
    logic [7:0] z_count;
    logic       busy;
    logic       err;

    pulse_mode_sequencer_if dp ();

    assign {dp.ny2, dp.ny1} = {dp.y2, dp.y1} + 2'd1;
    assign dp.z             = dp.y2 & dp.y1;

    pulse_mode_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (8)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .btn_3   (btn_3),
        .btn_2   (btn_2),
        .btn_0   (btn_0),
        .dp      (dp),
        .z_last  (z_last),
        .z_count (z_count),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] x;
        logic [1:0] y;
        logic       zl;
        logic [7:0] cnt;
    } exp_t;

    exp_t       q[$];
    int         n_tests  = 0;
    int         n_fail   = 0;
    int         n_pulses = 0;
    logic [1:0] m_y      = 2'd0;
    logic [7:0] m_cnt    = 8'd0;
    logic [2:0] w_x;

    assign w_x = {dp.x3, dp.x2, dp.x1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: stub datapath is a mod-4 counter with z at state 3.
    task automatic expect_pulse(input logic [2:0] x);
        exp_t e;
        e.x   = x;
        e.zl  = (m_y == 2'd3);
        m_cnt = m_cnt + {7'd0, e.zl};
        m_y   = m_y + 2'd1;
        e.y   = m_y;
        e.cnt = m_cnt;
        q.push_back(e);
    endtask

    // Monitor: evaluates each pulse when x returns to zero.
    logic [2:0] mon_prev  = 3'b000;
    int         mon_width = 0;
    int         mon_gap   = 100;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            mon_prev  = 3'b000;
            mon_width = 0;
            mon_gap   = 100;
        end else begin
            if (w_x != 3'b000) begin
                if (mon_prev == 3'b000) begin
                    check("gap_before_pulse", 32'(mon_gap >= 2), 32'd1);
                    mon_width = 0;
                end
                mon_width++;
                check("x_onehot", $countones(w_x), 32'd1);
                check("busy_during_x", busy, 32'd1);
            end else if (mon_prev != 3'b000) begin
                n_pulses++;
                mon_gap = 0;
                if (q.size() == 0) begin
                    check("unexpected_pulse", mon_prev, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("pulse_x", mon_prev, e.x);
                    check("pulse_width", mon_width, 32'd2);
                    check("commit_y", {dp.y2, dp.y1}, e.y);
                    check("commit_z_last", z_last, e.zl);
                    check("commit_z_count", z_count, e.cnt);
                end
            end
            if (w_x == 3'b000) mon_gap++;
            mon_prev = w_x;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        btn_3 = 1'b0;
        btn_2 = 1'b0;
        btn_0 = 1'b0;
        tick(3);
        rst   = 1'b0;
        m_y   = 2'd0;
        m_cnt = 8'd0;
        q.delete();
    endtask

    task automatic set_btns(input logic [2:0] v);
        btn_3 = v[0];
        btn_2 = v[1];
        btn_0 = v[2];
    endtask

    task automatic press(input logic [2:0] v, input int hold);
        set_btns(v);
        tick(hold);
        set_btns(3'b000);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
        check(name, q.size(), 32'd0);
        tick(14);
    endtask

    initial begin
        int snap;

        do_reset();

        // Idle after reset: everything at zero.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_after_reset", {w_x, dp.y2, dp.y1, busy, err, z_count}, 32'd0);
        end
        tick(1);

        // Single x1 request.
        expect_pulse(3'b001);
        press(3'b001, 10);
        wait_drain("x1_drain");
        check("x1_count", n_pulses, 32'd1);

        // Four btn_2 presses walk y through 01,10,11,00.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            expect_pulse(3'b010);
            press(3'b010, 10);
            wait_drain("x2_drain");
        end
        @(negedge clk);
        check("x2_final_y", {dp.y2, dp.y1}, 32'd0);
        check("x2_final_z_last", z_last, 32'd1);
        check("x2_final_z_count", z_count, 32'd1);
        check("x2_err", err, 32'd0);
        tick(1);

        // btn_2 then btn_0 one cycle later: both served in order.
        expect_pulse(3'b010);
        expect_pulse(3'b100);
        btn_2 = 1'b1;
        tick(1);
        btn_0 = 1'b1;
        tick(10);
        set_btns(3'b000);
        wait_drain("x2_x3_drain");
        @(negedge clk);
        check("x2_x3_y", {dp.y2, dp.y1}, 32'd2);
        check("x2_x3_err", err, 32'd0);
        tick(1);

        // 3-cycle glitch on btn_0 must not register.
        snap = n_pulses;
        press(3'b100, 3);
        tick(20);
        check("glitch_no_pulse", n_pulses, snap);
        check("glitch_y", {dp.y2, dp.y1}, 32'd2);
        check("glitch_err", err, 32'd0);

        // Simultaneous btn_3 and btn_0: dropped, sticky error.
        press(3'b101, 10);
        tick(20);
        check("simul_no_pulse", n_pulses, snap);
        check("simul_y", {dp.y2, dp.y1}, 32'd2);
        check("simul_err", err, 32'd1);
        tick(30);
        check("simul_err_sticky", err, 32'd1);

        // Reset during APPLY abandons the pulse.
        do_reset();
        check("reset_clears_err", err, 32'd0);
        btn_3 = 1'b1;
        begin
            int k;
            for (k = 0; k < 60; k++) begin
                @(negedge clk);
                if (w_x != 3'b000) break;
            end
            check("apply_reached", 32'(k < 60), 32'd1);
        end
        rst   = 1'b1;
        btn_3 = 1'b0;
        @(negedge clk);
        check("rst_apply_x", w_x, 32'd0);
        check("rst_apply_y", {dp.y2, dp.y1}, 32'd0);
        check("rst_apply_busy", busy, 32'd0);
        check("rst_apply_z_count", z_count, 32'd0);
        tick(2);
        rst  = 1'b0;
        snap = n_pulses;
        tick(25);
        check("rst_apply_no_commit", n_pulses, snap);
        check("rst_apply_y_after", {dp.y2, dp.y1}, 32'd0);
        check("queue_empty", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_mode_sequencer.md
Name: pulse_mode_sequencer

Overview:
- Clocked controller that drives the team's combinational pulse-mode state-machine blocks, such as the mod-4 three-input machine, from EGO1 push-buttons.
- Conditions three buttons (synchronise, debounce, edge-detect) and queues presses.
- Grants one input pulse at a time, enforcing the pulse-mode rule of at most one input high and a return to all-zero between pulses.
- Owns the state register {y2,y1}: samples the datapath's ny2/ny1/z while the pulse is applied, commits the next state, and counts z events.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a button level (10 ms @100 MHz; benches use 4)
CNT_W, 8, width of the z event counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn_3  in  1  raw button, requests pulse x1
btn_2  in  1  raw button, requests pulse x2
btn_0  in  1  raw button, requests pulse x3
ny2  in  1  next-state bit 2 from combinational datapath
ny1  in  1  next-state bit 1 from combinational datapath
z  in  1  Mealy output from datapath
x1  out  1  pulse input to datapath
x2  out  1  pulse input to datapath
x3  out  1  pulse input to datapath
y2  out  1  registered state bit 2 (to datapath and LED)
y1  out  1  registered state bit 1 (to datapath and LED)
z_last  out  1  z captured at the last commit
z_count  out  CNT_W  number of commits with z=1, wraps modulo 2^CNT_W
busy  out  1  high when FSM is not IDLE
err  out  1  sticky pulse-mode violation flag

Behaviour:
- Reset: when rst=1 at a clk edge, all of the following are cleared:
  - y2=y1=0, z_last=0, z_count=0, err=0
  - x1=x2=x3=0, busy=0, FSM=IDLE
  - pending[2:0]=0, debounced levels=0, debounce counters=0, synchroniser flops=0
- Reset mid-operation: an in-flight pulse is abandoned with no commit; x outputs are 0 from the first cycle after the reset edge.
- Sync: each button passes through two flops.
- Debounce, per button:
  - Counter increments while the synced level differs from the debounced level, and clears when they match.
  - On reaching DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Shorter glitches produce no change.
- Edge detect: a 0->1 transition of a debounced level is a request edge, one cycle wide.
- Request latch, pending[k]:
  - A single request edge in a cycle sets its pending bit.
  - Two or more request edges in the same cycle: all are discarded and err is set (simultaneous inputs are illegal in pulse mode).
  - An edge for a button whose pending bit is already set: dropped, and err is set.
  - An edge for a pending bit being cleared in the same cycle (COMMIT): re-sets the bit (new request wins).
- FSM, one-hot x outputs, x is registered:
  - IDLE: x=000. If pending is nonzero, grant with fixed priority x1 > x2 > x3 and go to APPLY.
  - APPLY: the granted x is 1 (datapath settles) -> COMMIT.
  - COMMIT: the granted x is still 1. At the end of the cycle: {y2,y1}<={ny2,ny1}, z_last<=z, z_count<=z_count+z, pending[grant] cleared -> GAP.
  - GAP: x=000 (mandatory all-zero separator) -> IDLE.
- Latency:
  - Request edge in cycle t gives pending set at t+1.
  - APPLY at t+2 (if idle), COMMIT at t+3; new y visible at t+4.
  - Back-to-back grants are spaced 4 cycles apart (IDLE, APPLY, COMMIT, GAP).
- x outputs are never more than one-hot; x is never high in IDLE or GAP.
- err stays set until rst.

Test Plan:
- Bench setup: DEBOUNCE_CYCLES=4, CNT_W=8. Stub datapath: {ny2,ny1}=({y2,y1}+1) mod 4, z=(y==3).
- Reset then idle 20 cycles -> y=00, x=000, z_count=0, busy=0, err=0 throughout.
- Press btn_3 held 10 cycles -> exactly one x1 pulse, 2 cycles wide; y=01 four cycles after the request edge; z_count=0.
- Four separate btn_2 presses -> y sequence 01,10,11,00; on the 4th commit z_last=1 and z_count=1; x2 is low for at least 2 cycles between pulses.
- btn_3 and btn_0 debounced edges in the same cycle -> no pulse issued, y unchanged, err=1 and stays 1 until rst.
- btn_2 edge, then btn_0 edge 1 cycle later while busy -> x2 pulse, GAP, then x3 pulse; y advances by 2 in total; err=0.
- Glitch of 3 cycles on btn_0 -> no request. Separately, rst asserted during APPLY -> x=000 next cycle, y=00, no commit.
